// File: rtl/fir_tap_if.sv
// Tap-load sequencer bus: reload request handshake, coefficient ROM port,
// filter tap-write port and the filter enable/flush controls.
interface fir_tap_if #(
  parameter int unsigned NTAPS  = 16,
  parameter int unsigned NBANKS = 4,
  parameter int unsigned TW     = 16
);
  localparam int unsigned IW = $clog2(NTAPS);
  localparam int unsigned BW = (NBANKS > 1) ? $clog2(NBANKS) : 1;

  logic          i_req_valid;
  logic [BW-1:0] i_req_bank;
  logic          o_req_ready;
  logic [BW+IW-1:0] o_rom_addr;
  logic [TW-1:0] i_rom_data;
  logic [TW-1:0] o_tap;
  logic          o_tap_wr;
  logic          i_sample_ce;
  logic          o_fir_ce;
  logic          o_sample_zero;
  logic          o_result_valid;
  logic [BW-1:0] o_bank;

  // Host / ROM / filter side
  modport master (
    output i_req_valid, i_req_bank, i_rom_data, i_sample_ce,
    input  o_req_ready, o_rom_addr, o_tap, o_tap_wr, o_fir_ce,
           o_sample_zero, o_result_valid, o_bank
  );

  // Sequencer side
  modport slave (
    input  i_req_valid, i_req_bank, i_rom_data, i_sample_ce,
    output o_req_ready, o_rom_addr, o_tap, o_tap_wr, o_fir_ce,
           o_sample_zero, o_result_valid, o_bank
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// Loads a coefficient bank from ROM into the FIR tap port, flushes the delay
// line with NTAPS zero samples, then gates the filter for normal running.
module fir_tap_sequencer #(
  parameter int unsigned NTAPS  = 16,
  parameter int unsigned NBANKS = 4,
  parameter int unsigned TW     = 16
) (
  input  logic     i_clk,
  input  logic     i_reset,
  fir_tap_if.slave bus
);
  localparam int unsigned IW = $clog2(NTAPS);
  localparam int unsigned BW = (NBANKS > 1) ? $clog2(NBANKS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] flush_cnt_q, flush_cnt_d;
  logic [BW-1:0] bank_q, bank_d;
  logic          last_q, last_d;
  logic          tap_wr_q, tap_wr_d;
  logic          valid_q, valid_d;
  logic          ready_c;
  logic          accept_c;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      flush_cnt_q <= '0;
      bank_q      <= '0;
      last_q      <= 1'b0;
      tap_wr_q    <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      flush_cnt_q <= flush_cnt_d;
      bank_q      <= bank_d;
      last_q      <= last_d;
      tap_wr_q    <= tap_wr_d;
      valid_q     <= valid_d;
    end
  end

  assign ready_c  = (state_q == IDLE) || (state_q == RUN);
  assign accept_c = bus.i_req_valid && ready_c;

  // last_q marks the extra LOAD cycle in which the final ROM word lands
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    flush_cnt_d = flush_cnt_q;
    bank_d      = bank_q;
    last_d      = last_q;
    tap_wr_d    = 1'b0;
    unique case (state_q)
      IDLE, RUN: begin
        if (accept_c) begin
          bank_d      = bus.i_req_bank;
          idx_d       = '0;
          last_d      = 1'b0;
          flush_cnt_d = '0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        tap_wr_d = !last_q;
        if (idx_q != IW'(NTAPS - 1)) begin
          idx_d = idx_q + IW'(1);
        end else begin
          last_d = 1'b1;
        end
        if (last_q) begin
          flush_cnt_d = '0;
          state_d     = FLUSH;
        end
      end
      FLUSH: begin
        if (bus.i_sample_ce) begin
          if (flush_cnt_q == IW'(NTAPS - 1)) begin
            flush_cnt_d = '0;
            state_d     = RUN;
          end else begin
            flush_cnt_d = flush_cnt_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == RUN);
  end

  assign bus.o_req_ready    = ready_c;
  assign bus.o_rom_addr     = {bank_q, (state_q == LOAD) ? idx_q : IW'(0)};
  assign bus.o_tap          = bus.i_rom_data;
  assign bus.o_tap_wr       = tap_wr_q;
  assign bus.o_fir_ce       = ((state_q == FLUSH) || (state_q == RUN)) && bus.i_sample_ce;
  assign bus.o_sample_zero  = (state_q == FLUSH);
  assign bus.o_result_valid = valid_q;
  assign bus.o_bank         = bank_q;
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench for fir_tap_sequencer: ROM returns address*3, expected
// taps are queued at each accepted request and popped on every tap write.
module tb_fir_tap_sequencer;
  localparam int unsigned NTAPS  = 16;
  localparam int unsigned NBANKS = 4;
  localparam int unsigned TW     = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [TW-1:0] exp_q[$];

  fir_tap_if #(.NTAPS(NTAPS), .NBANKS(NBANKS), .TW(TW)) bus ();

  fir_tap_sequencer #(.NTAPS(NTAPS), .NBANKS(NBANKS), .TW(TW)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Synchronous coefficient ROM: data = address * 3
  always @(posedge clk) bus.i_rom_data <= 16'(bus.o_rom_addr) * 16'd3;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Every tap write must match the next queued coefficient
  always @(negedge clk) begin
    if (bus.o_tap_wr === 1'b1) begin
      if (exp_q.size() == 0) check("tap_extra", 32'd1, 32'd0);
      else check("tap_value", 32'(bus.o_tap), 32'(exp_q.pop_front()));
    end
  end

  task automatic start_req(input int b);
    bus.i_req_valid = 1'b1;
    bus.i_req_bank  = 2'(b);
  endtask

  // Call just after a negedge; returns 2ns after the accepting edge
  task automatic accept_edge(input int b);
    int n = 0;
    while (!bus.o_req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(n < 200), 32'd1);
    @(posedge clk);
    for (int i = 0; i < int'(NTAPS); i++) exp_q.push_back(TW'((b * int'(NTAPS) + i) * 3));
    #2;
    bus.i_req_valid = 1'b0;
    bus.i_req_bank  = 2'($urandom);
  endtask

  task automatic request(input int b);
    start_req(b);
    accept_edge(b);
  endtask

  // Sample strobe held high through LOAD to confirm it is gated off
  task automatic load_check(input int b);
    bus.i_sample_ce = 1'b1;
    for (int i = 0; i < int'(NTAPS); i++) begin
      @(negedge clk);
      check("rom_addr", 32'(bus.o_rom_addr), 32'(b * int'(NTAPS) + i));
      check("load_tap_wr", 32'(bus.o_tap_wr), 32'(i != 0));
      check("load_fir_ce", 32'(bus.o_fir_ce), 32'd0);
      check("load_ready", 32'(bus.o_req_ready), 32'd0);
      check("load_valid", 32'(bus.o_result_valid), 32'd0);
      check("load_bank", 32'(bus.o_bank), 32'(b));
    end
    @(negedge clk);
    check("last_tap_wr", 32'(bus.o_tap_wr), 32'd1);
    check("last_fir_ce", 32'(bus.o_fir_ce), 32'd0);
    check("last_zero", 32'(bus.o_sample_zero), 32'd0);
  endtask

  task automatic flush(input int period);
    int pulses = 0;
    int cyc = 0;
    while (pulses < int'(NTAPS) && cyc < 2000) begin
      @(posedge clk);
      #2 bus.i_sample_ce = ((cyc % period) == period - 1);
      @(negedge clk);
      check("flush_zero", 32'(bus.o_sample_zero), 32'd1);
      check("flush_fir_ce", 32'(bus.o_fir_ce), 32'(bus.i_sample_ce));
      check("flush_valid", 32'(bus.o_result_valid), 32'd0);
      check("flush_ready", 32'(bus.o_req_ready), 32'd0);
      check("flush_tap_wr", 32'(bus.o_tap_wr), 32'd0);
      if (bus.i_sample_ce) pulses++;
      cyc++;
    end
    check("flush_pulses", 32'(pulses), 32'(NTAPS));
    @(posedge clk);
    #2 bus.i_sample_ce = 1'b1;
    @(negedge clk);
    check("run_valid", 32'(bus.o_result_valid), 32'd1);
    check("run_zero", 32'(bus.o_sample_zero), 32'd0);
    check("run_fir_ce", 32'(bus.o_fir_ce), 32'd1);
    check("run_ready", 32'(bus.o_req_ready), 32'd1);
    check("tap_count", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.i_req_valid = 1'($urandom);
    bus.i_req_bank  = 2'($urandom);
    bus.i_sample_ce = 1'($urandom);
    #1 rst = 1'b1;
    #1;
    check("rst_tap_wr", 32'(bus.o_tap_wr), 32'd0);
    check("rst_fir_ce", 32'(bus.o_fir_ce), 32'd0);
    check("rst_zero", 32'(bus.o_sample_zero), 32'd0);
    check("rst_valid", 32'(bus.o_result_valid), 32'd0);
    check("rst_bank", 32'(bus.o_bank), 32'd0);
    bus.i_req_valid = 1'b0;
    bus.i_sample_ce = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(bus.o_req_ready), 32'd1);
    check("idle_fir_ce", 32'(bus.o_fir_ce), 32'd0);
    check("idle_addr", 32'(bus.o_rom_addr), 32'd0);

    // Bank 2 with a bank-1 request held throughout LOAD/FLUSH
    request(2);
    start_req(1);
    load_check(2);
    flush(4);
    accept_edge(1);
    load_check(1);
    flush(1);

    // Reset on the 5th tap write of a bank-2 load
    request(2);
    for (int c = 0; c < 6; c++) @(negedge clk);
    check("pre_rst_tap_wr", 32'(bus.o_tap_wr), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_tap_wr", 32'(bus.o_tap_wr), 32'd0);
    check("mid_rst_bank", 32'(bus.o_bank), 32'd0);
    check("mid_rst_ready", 32'(bus.o_req_ready), 32'd1);
    check("mid_rst_addr", 32'(bus.o_rom_addr), 32'd0);
    exp_q.delete();
    bus.i_sample_ce = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("post_rst_tap_wr", 32'(bus.o_tap_wr), 32'd0);
    request(3);
    load_check(3);
    flush(1);

    // Back-to-back reloads of bank 0 from RUN
    request(0);
    load_check(0);
    flush(2);
    request(0);
    load_check(0);
    flush(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Sequencer that owns the tap-load path of the generic FIR filter. It accepts bank-select reload requests over a valid/ready handshake and reads the selected coefficient bank from a synchronous coefficient ROM. It streams the taps into the filter's tap-write port, then flushes the delay line with zero samples before declaring results valid. It sits between the control/host logic, the coefficient ROM and the FIR datapath, and gates the filter clock-enable throughout.

## Interface
- NTAPS, 16, taps per bank; power of two, ≥2
- NBANKS, 4, coefficient banks in ROM; power of two, ≥1
- TW, 16, tap width
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_req_valid  in  1  reload request
- i_req_bank  in  log2(NBANKS)  bank to load; sampled on handshake
- o_req_ready  out  1  request can be accepted
- o_rom_addr  out  log2(NBANKS)+log2(NTAPS)  ROM address {bank, idx}
- i_rom_data  in  TW  ROM data; valid one cycle after o_rom_addr
- o_tap  out  TW  tap value to filter; combinational copy of i_rom_data
- o_tap_wr  out  1  tap write strobe to filter
- i_sample_ce  in  1  upstream sample strobe
- o_fir_ce  out  1  filter clock-enable
- o_sample_zero  out  1  force filter sample input to 0
- o_result_valid  out  1  filter output meaningful
- o_bank  out  log2(NBANKS)  currently loaded/loading bank

## Operation
- States: IDLE, LOAD, FLUSH, RUN.
- Handshake completes on a rising edge where i_req_valid && o_req_ready. o_req_ready = 1 in IDLE and RUN, 0 in LOAD and FLUSH.
- On accept, o_bank <= i_req_bank, idx <= 0, and the state moves to LOAD. This applies from RUN too: RUN is aborted and o_result_valid drops.
- LOAD:
  - o_rom_addr = {o_bank, idx}. idx increments every cycle and saturates at NTAPS-1.
  - o_tap_wr is a one-cycle-delayed "address issued" flag. It is high for exactly NTAPS consecutive cycles, starting the cycle after idx=0 is issued.
  - Taps are written in order idx 0 first, idx NTAPS-1 last.
  - LOAD lasts NTAPS+1 cycles, then the state moves to FLUSH.
  - o_fir_ce = 0 throughout.
- FLUSH:
  - o_sample_zero = 1 and o_fir_ce = i_sample_ce.
  - A flush counter counts i_sample_ce pulses. On the edge that registers the NTAPS-th pulse, the state moves to RUN.
- RUN: o_fir_ce = i_sample_ce, o_sample_zero = 0, o_result_valid = 1.
- IDLE: o_fir_ce = 0, o_tap_wr = 0, o_result_valid = 0. o_rom_addr holds {o_bank, 0}.
- Outside LOAD, o_rom_addr is {o_bank, 0}.
- i_req_bank is ignored except at handshake. Requests presented while o_req_ready = 0 wait; the sequencer neither drops nor queues them, and the requester holds valid.

## Timing
- Reset (asynchronous assert): state = IDLE, idx = 0, flush count = 0.
- Output values during reset: o_bank = 0, o_tap_wr = 0, o_fir_ce = 0, o_sample_zero = 0, o_result_valid = 0, o_req_ready = 1 after deassert.
- Reset mid-LOAD or mid-FLUSH: no o_tap_wr is issued after reset assertion, and no partial state survives.
- Accept at edge k:
  - Cycle k+1: LOAD, addr idx 0.
  - Cycles k+2 … k+NTAPS+1: o_tap_wr = 1.
  - Cycle k+NTAPS+2: FLUSH.
  - With i_sample_ce held high, RUN begins at cycle k+2·NTAPS+2.
- An i_sample_ce pulse on the last LOAD cycle is discarded: fir_ce stays 0 and it is not counted.
- All state transitions are on rising i_clk. o_fir_ce, o_sample_zero and o_tap are combinational from state and inputs. o_tap_wr and o_result_valid are functions of registered state only.

## Test plan
- Reset values: assert reset mid-clock with random inputs → all outputs at their reset values immediately. After deassert, o_req_ready = 1 and o_fir_ce = 0 even with i_sample_ce = 1.
- Load bank 2, NTAPS = 16, NBANKS = 4, ROM data = address·3:
  - o_rom_addr steps 32…47.
  - o_tap_wr is high for 16 cycles, starting at k+2, with o_tap = 96, 99, …, 141.
  - o_fir_ce = 0 throughout LOAD.
- Flush pacing, i_sample_ce every 4th cycle:
  - o_sample_zero = 1 and o_fir_ce mirrors the strobe for 16 pulses.
  - RUN and o_result_valid = 1 the cycle after the 16th pulse.
- Request during LOAD, bank 1, valid held:
  - o_req_ready = 0 until RUN. Accepted on the first RUN cycle.
  - o_result_valid drops, and the second load walks addresses 16…31.
- Reset asserted on the 5th o_tap_wr cycle → o_tap_wr = 0 immediately, state IDLE, o_bank = 0. A new request for bank 3 then loads addresses 48…63 cleanly.
- Back-to-back accepts in RUN on bank 0 then bank 0: each produces exactly 16 tap writes and a full 16-pulse flush.
